mdu_rr_scheduler: RTL and testbench

- Shares one 64-bit shift/add multiply-divide unit among NUM_REQ requesters.
- Arbitration is round-robin.
- Each accepted request's operands and mode are latched and held stable for the whole operation.
- The unit is sequenced via start/ready; the 129-bit result is returned to the owning requester over a valid/ready response channel.
- Sits between client pipelines and the multiply/divide datapath top.

---
 rtl/mdu_sched_pkg.sv | 19 +
 rtl/mdu_rr_scheduler_rr_arbiter.sv | 35 +++
 rtl/mdu_rr_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_mdu_rr_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared types and sizing helpers for the multiply/divide request scheduler.
package mdu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } sched_state_e;

    localparam int DATA_W_DEF = 64;

    // Result carries the full double-width product plus one status/sign bit.
    function automatic int RES_W(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mdu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from rr_ptr upward (mod NUM_REQ)
// and returns the first requester found as one-hot grant plus binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] pos_s;
    logic             take_s;
    logic             found_s;

    // Rotating priority scan; each position is visited exactly once
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        found_s   = 1'b0;
        pos_s     = {IDX_W{1'b0}};
        take_s    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s        = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            take_s       = req[pos_s] & ~found_s;
            grant[pos_s] = take_s;
            grant_idx    = take_s ? pos_s : grant_idx;
            found_s      = found_s | take_s;
        end
        grant_valid = found_s;
    end

endmodule

// File: rtl/mdu_rr_scheduler.sv
// Round-robin scheduler sharing one multiply/divide unit among NUM_REQ clients.
// Optional MDU_RR_SCHEDULER_PERF_EN adds saturating perf_ops/perf_busy counters.
module mdu_rr_scheduler
    import mdu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]          req_m_d,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [2*DATA_W:0]           rsp_result,
    output logic [DATA_W-1:0]           mdu_a,
    output logic [DATA_W-1:0]           mdu_b,
    output logic                        mdu_m_d,
    output logic                        mdu_start,
    input  logic [2*DATA_W:0]           mdu_result,
    input  logic                        mdu_ready
`ifdef MDU_RR_SCHEDULER_PERF_EN
    ,
    output logic [31:0]                 perf_ops,
    output logic [31:0]                 perf_busy
`endif
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int RES_WIDTH = RES_W(DATA_W);

    sched_state_e           state_r;
    sched_state_e           state_s;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W-1:0]       next_ptr_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic [NUM_REQ-1:0]     owner_onehot_s;
    logic [NUM_REQ-1:0]     rsp_valid_r;
    logic                   grant_valid_s;
    logic                   accept_s;
    logic                   capture_s;
    logic                   rsp_hs_s;
    logic [DATA_W-1:0]      sel_a_s;
    logic [DATA_W-1:0]      sel_b_s;
    logic                   sel_m_d_s;
    logic [DATA_W-1:0]      mdu_a_r;
    logic [DATA_W-1:0]      mdu_b_r;
    logic                   mdu_m_d_r;
    logic                   mdu_start_r;
    logic [RES_WIDTH-1:0]   result_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Next-state decode and handshake strobes
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        rsp_hs_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!mdu_ready) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (mdu_ready) begin
                    capture_s = 1'b1;
                    state_s   = RESPOND;
                end else begin
                    state_s   = WAIT_DONE;
                end
            end
            RESPOND: begin
                if (rsp_ready[owner_r]) begin
                    rsp_hs_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = RESPOND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Accept strobe is only offered from IDLE and is held off while reset is asserted
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if ((state_r == IDLE) && !reset) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Operand mux driven by the one-hot grant, plus owner decode and pointer rotate
    always_comb begin
        sel_a_s        = {DATA_W{1'b0}};
        sel_b_s        = {DATA_W{1'b0}};
        sel_m_d_s      = 1'b0;
        owner_onehot_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s   = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
            sel_b_s   = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
            sel_m_d_s = sel_m_d_s | (req_m_d[i] & grant_s[i]);
        end
        owner_onehot_s[owner_r] = 1'b1;
        if (int'(grant_idx_s) == (NUM_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + IDX_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, start pulse, result capture and response valid
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r    <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            mdu_a_r     <= {DATA_W{1'b0}};
            mdu_b_r     <= {DATA_W{1'b0}};
            mdu_m_d_r   <= 1'b0;
            mdu_start_r <= 1'b0;
            result_r    <= {RES_WIDTH{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
        end else begin
            // start is high exactly during the ISSUE cycle following an accept
            mdu_start_r <= accept_s;
            if (accept_s) begin
                mdu_a_r   <= sel_a_s;
                mdu_b_r   <= sel_b_s;
                mdu_m_d_r <= sel_m_d_s;
                owner_r   <= grant_idx_s;
                rr_ptr_r  <= next_ptr_s;
            end
            if (capture_s) begin
                result_r    <= mdu_result;
                rsp_valid_r <= owner_onehot_s;
            end else if (rsp_hs_s) begin
                rsp_valid_r <= {NUM_REQ{1'b0}};
            end
        end
    end

    assign mdu_a      = mdu_a_r;
    assign mdu_b      = mdu_b_r;
    assign mdu_m_d    = mdu_m_d_r;
    assign mdu_start  = mdu_start_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = result_r;

`ifdef MDU_RR_SCHEDULER_PERF_EN
    logic [31:0] perf_ops_r;
    logic [31:0] perf_busy_r;

    // Saturating completed-operation and busy-cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_r  <= 32'd0;
            perf_busy_r <= 32'd0;
        end else begin
            if (rsp_hs_s && (perf_ops_r != 32'hFFFF_FFFF)) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end
            if ((state_r != IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_r;
    assign perf_busy = perf_busy_r;
`endif

endmodule

// File: tb/tb_mdu_rr_scheduler.sv
// Scoreboard bench for mdu_rr_scheduler with a behavioural shift/add unit model.
module tb_mdu_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int RW = 2 * W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_m_d, rsp_valid, rsp_ready;
    logic [N*W-1:0]    req_a, req_b;
    logic [RW-1:0]     rsp_result, mdu_result;
    logic [W-1:0]      mdu_a, mdu_b;
    logic              mdu_m_d, mdu_start, mdu_ready;
`ifdef MDU_RR_SCHEDULER_PERF_EN
    logic [31:0]       perf_ops, perf_busy;
`endif

    typedef struct {
        int            idx;
        logic [RW-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   rsp_seen = 0;
    int   unit_cnt;

    always #5 clk = ~clk;

    mdu_rr_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_m_d    (req_m_d),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .mdu_a      (mdu_a),
        .mdu_b      (mdu_b),
        .mdu_m_d    (mdu_m_d),
        .mdu_start  (mdu_start),
        .mdu_result (mdu_result),
        .mdu_ready  (mdu_ready)
`ifdef MDU_RR_SCHEDULER_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy)
`endif
    );

    // Unit model: busy the cycle after start, done 66 cycles later; operands sampled at completion
    always @(posedge clk) begin
        if (reset) begin
            mdu_ready  <= 1'b1;
            unit_cnt   <= 0;
            mdu_result <= '0;
        end else if (mdu_start) begin
            mdu_ready <= 1'b0;
            unit_cnt  <= 66;
        end else if (!mdu_ready) begin
            if (unit_cnt == 1) begin
                mdu_ready  <= 1'b1;
                mdu_result <= RW'(mdu_a) * RW'(mdu_b);
            end
            unit_cnt <= unit_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push_exp(input int i, input logic [RW-1:0] r);
        exp_t e;
        e.idx = i;
        e.res = r;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_seen(input int target, input int bound, input string name);
        int n = 0;
        while (rsp_seen < target && n < bound) begin
            tick();
            n++;
        end
        if (rsp_seen < target) timeout(name);
    endtask

    task automatic accept_one(input int i, input string name);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 200) begin
            tick();
            n++;
        end
        if (req_ready == '0) begin
            timeout(name);
        end else begin
            chk(name, RW'(req_ready), RW'(4'b0001 << i));
            tick();
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (mdu_ready && n < 20) begin
            tick();
            n++;
        end
        if (mdu_ready) timeout(name);
    endtask

    // Monitor: pops the scoreboard on every response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ((rsp_valid & rsp_ready) != '0)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_owner", RW'(rsp_valid), RW'(4'b0001 << e.idx));
                    chk("rsp_result", rsp_result, e.res);
                end
                rsp_seen++;
            end
        end
    end

    initial begin
        int base;
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_m_d   = '0;
        rsp_ready = '0;
        tick();
        tick();
        chk("rst_req_ready", RW'(req_ready), '0);
        chk("rst_rsp_valid", RW'(rsp_valid), '0);
        chk("rst_start", RW'(mdu_start), '0);
        chk("rst_mdu_a", RW'(mdu_a), '0);
        chk("rst_result", rsp_result, '0);
        reset     = 1'b0;
        req_valid = '0;
        tick();

        // Single request from requester 0: 7*6
        set_op(0, 64'd7, 64'd6);
        push_exp(0, 129'd42);
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", RW'(req_ready), RW'(4'b0001));
        tick();
        req_valid = '0;
        chk("t1_start_hi", RW'(mdu_start), RW'(1'b1));
        chk("t1_mdu_a", RW'(mdu_a), RW'(64'd7));
        chk("t1_ready_off", RW'(req_ready), '0);
        tick();
        chk("t1_start_lo", RW'(mdu_start), '0);
        rsp_ready = 4'b1111;
        wait_seen(1, 200, "t1_rsp");

        // All four requesters continuously valid from rr_ptr=0
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, W'(i + 2), 64'd10);
        push_exp(0, 129'd20);
        push_exp(1, 129'd30);
        push_exp(2, 129'd40);
        push_exp(3, 129'd50);
        push_exp(0, 129'd20);
        base      = rsp_seen;
        req_valid = 4'b1111;
        wait_seen(base + 5, 800, "t2_rsp");
        req_valid = '0;

        // Sparse requesters 1 and 3 from rr_ptr=0
        do_reset();
        set_op(1, 64'd3, 64'd5);
        set_op(3, 64'd9, 64'd11);
        req_m_d = 4'b0010;
        push_exp(1, 129'd15);
        push_exp(3, 129'd99);
        push_exp(1, 129'd15);
        base      = rsp_seen;
        req_valid = 4'b1010;
        #1;
        chk("t3_first_grant", RW'(req_ready), RW'(4'b0010));
        tick();
        chk("t3_m_d", RW'(mdu_m_d), RW'(1'b1));
        wait_seen(base + 3, 600, "t3_rsp");
        req_valid = '0;
        req_m_d   = '0;

        // Operand change while the unit is busy
        set_op(2, 64'd1000, 64'd3);
        push_exp(2, 129'd3000);
        base      = rsp_seen;
        req_valid = 4'b0100;
        accept_one(2, "t4_grant");
        wait_busy("t4_busy");
        tick();
        set_op(2, 64'd5, 64'd3);
        tick();
        tick();
        chk("t4_mdu_a_held", RW'(mdu_a), RW'(64'd1000));
        wait_seen(base + 1, 200, "t4_rsp");

        // Response back-pressure with another request pending
        rsp_ready = '0;
        set_op(0, 64'd4, 64'd4);
        set_op(1, 64'd2, 64'd2);
        push_exp(0, 129'd16);
        push_exp(1, 129'd4);
        base      = rsp_seen;
        req_valid = 4'b0001;
        accept_one(0, "t5_grant");
        req_valid[1] = 1'b1;
        for (int n = 0; n < 200 && rsp_valid == '0; n++) tick();
        chk("t5_rsp_valid", RW'(rsp_valid), RW'(4'b0001));
        for (int n = 0; n < 10; n++) begin
            chk("t5_hold_valid", RW'(rsp_valid), RW'(4'b0001));
            chk("t5_hold_result", rsp_result, 129'd16);
            chk("t5_no_grant", RW'(req_ready), '0);
            tick();
        end
        rsp_ready = 4'b0001;
        tick();
        chk("t5_valid_drop", RW'(rsp_valid), '0);
        chk("t5_next_grant", RW'(req_ready), RW'(4'b0010));
        tick();
        chk("t5_start", RW'(mdu_start), RW'(1'b1));
        req_valid = '0;
        rsp_ready = 4'b1111;
        wait_seen(base + 2, 300, "t5_rsp");

        // Reset while waiting for the unit to finish
        base = rsp_seen;
        set_op(3, 64'd1, 64'd1);
        req_valid = 4'b1000;
        accept_one(3, "t6_grant");
        wait_busy("t6_busy");
        for (int n = 0; n < 5; n++) tick();
        req_valid = 4'b1111;
        reset     = 1'b1;
        tick();
        chk("t6_req_ready", RW'(req_ready), '0);
        chk("t6_rsp_valid", RW'(rsp_valid), '0);
        chk("t6_start", RW'(mdu_start), '0);
        chk("t6_mdu_a", RW'(mdu_a), '0);
        chk("t6_mdu_b", RW'(mdu_b), '0);
        chk("t6_result", rsp_result, '0);
`ifdef MDU_RR_SCHEDULER_PERF_EN
        chk("t6_perf_ops", RW'(perf_ops), '0);
        chk("t6_perf_busy", RW'(perf_busy), '0);
`endif
        reset = 1'b0;
        #1;
        chk("t6_ptr_zero", RW'(req_ready), RW'(4'b0001));
        req_valid = '0;
        for (int n = 0; n < 100; n++) tick();
        chk("t6_no_rsp", RW'(rsp_seen - base), '0);
        chk("sb_empty", RW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
